cdb_arbiter: RTL and testbench

Completion-stage arbiter between the functional units and the physical register file. It holds one finished result per FU in a skid slot and selects up to `N` results per cycle with round-robin fairness. Selected results drive the PRF write ports, with value and PRN, and are broadcast as CDB tags to the RS, ROB and map table. FU backpressure is applied through a per-FU ready handshake.

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_arbiter_if.sv | 24 ++
 rtl/cdb_arbiter_rr_select.sv | 39 +++
 rtl/cdb_arbiter.sv | 89 ++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared result/write types and sizing for the completion arbiter
package cdb_arbiter_pkg;
  localparam int N              = 2;
  localparam int NUM_FU_DEFAULT = 8;
  localparam int PRN_W          = 6;
  localparam int DATA_W         = 32;

  typedef logic [PRN_W-1:0]  PRN;
  typedef logic [DATA_W-1:0] DATA;

  typedef struct packed {
    DATA value;
    PRN  prn;
  } PRF_WRITE;

  typedef struct packed {
    PRN  prn;
    DATA value;
  } FU_RESULT;
endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result handshake and PRF/CDB broadcast bundle
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT
);
  logic                        squash;
  logic [NUM_FU-1:0]           fu_valid;
  FU_RESULT                    fu_result [NUM_FU];
  logic [NUM_FU-1:0]           fu_ready;
  PRF_WRITE                    write_data [N];
  PRN                          cdb_prn [N];
  logic [$clog2(NUM_FU+1)-1:0] occupancy;

  modport slave (
    input  squash, fu_valid, fu_result,
    output fu_ready, write_data, cdb_prn, occupancy
  );

  modport master (
    output squash, fu_valid, fu_result,
    input  fu_ready, write_data, cdb_prn, occupancy
  );
endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// rtl/cdb_arbiter_rr_select.sv - round-robin pick of up to N requests starting at ptr
module rr_select
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT,
  parameter int PTR_W  = $clog2(NUM_FU),
  parameter int CNT_W  = $clog2(N+1)
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant [N],
  output logic [CNT_W-1:0]  count,
  output logic [PTR_W-1:0]  last
);
  always_comb begin
    int n;
    int j;
    logic [PTR_W-1:0] idx;
    for (int k = 0; k < N; k++) grant[k] = '0;
    n    = 0;
    j    = 0;
    idx  = '0;
    last = ptr;
    for (int i = 0; i < NUM_FU; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_FU) j = j - NUM_FU;
      idx = PTR_W'(j);
      if (req[idx] && n < N) begin
        // grant k goes to the k-th valid slot in scan order
        for (int k = 0; k < N; k++) begin
          if (k == n) grant[k][idx] = 1'b1;
        end
        last = idx;
        n    = n + 1;
      end
    end
    count = CNT_W'(n);
  end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU skid slots arbitrated onto N PRF write / CDB ports
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT,
  parameter int PTR_W  = $clog2(NUM_FU)
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(N+1);
  localparam int OCC_W = $clog2(NUM_FU+1);

  logic [NUM_FU-1:0] slot_valid;
  FU_RESULT          slot [NUM_FU];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [NUM_FU-1:0] grant [N];
  logic [CNT_W-1:0]  grant_count;
  logic [PTR_W-1:0]  last_grant;
  logic [NUM_FU-1:0] granted;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] accept;
  logic [OCC_W-1:0]  occ;

  rr_select #(.NUM_FU(NUM_FU), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_rr_select (
    .req   (slot_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .count (grant_count),
    .last  (last_grant)
  );

  // a squash cycle issues no grants, so nothing is written and no slot is freed by grant
  always_comb begin
    granted = '0;
    for (int k = 0; k < N; k++) begin
      if (!bus.squash) granted = granted | grant[k];
    end
  end

  assign ready    = reset ? (~slot_valid | granted) : '0;
  assign accept   = bus.fu_valid & ready;
  assign next_ptr = (int'(last_grant) == NUM_FU - 1) ? '0 : last_grant + PTR_W'(1);

  always_comb begin
    for (int k = 0; k < N; k++) begin
      bus.write_data[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[k][i] && !bus.squash) begin
          bus.write_data[k].value = slot[i].value;
          bus.write_data[k].prn   = slot[i].prn;
        end
      end
      bus.cdb_prn[k] = bus.write_data[k].prn;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_FU; i++) occ = occ + OCC_W'(slot_valid[i]);
  end

  assign bus.fu_ready  = ready;
  assign bus.occupancy = occ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else if (bus.squash) begin
      slot_valid <= '0;
    end else begin
      // prn 0 has no destination: handshake completes but the slot stays empty
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i] && bus.fu_result[i].prn != '0) slot_valid[i] <= 1'b1;
        else if (granted[i])                         slot_valid[i] <= 1'b0;
      end
      if (grant_count != '0) rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i] && !bus.squash && bus.fu_result[i].prn != '0) slot[i] <= bus.fu_result[i];
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table vectors, hand sequences and a PRN-keyed write scoreboard
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF    = 4;
  localparam int NROWS = 13;

  typedef struct {
    logic [NF-1:0]  valid;
    PRN [NF-1:0]    prn;
    logic           sq;
    logic [NF-1:0]  ready;
    PRN             w0;
    PRN             w1;
    int             occ;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [NROWS];
  FU_RESULT sb [$];
  int   hits [$];
  PRN   mon_prn;
  PRN   nxt [NF];
  logic [NF-1:0] exp_ready;

  cdb_arbiter_if #(.NUM_FU(NF)) bus ();

  cdb_arbiter #(.NUM_FU(NF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic DATA val_of(input PRN p);
    return (p == '0) ? 32'd7 : (32'hC0DE_0000 | DATA'(p));
  endfunction

  function automatic PRF_WRITE wexp(input PRN p);
    PRF_WRITE w;
    w.prn   = p;
    w.value = (p == '0) ? '0 : val_of(p);
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_fu(input int i, input PRN p, input DATA d);
    bus.fu_result[i].prn   = p;
    bus.fu_result[i].value = d;
  endtask

  task automatic idle_inputs();
    bus.fu_valid = '0;
    bus.squash   = 1'b0;
    for (int i = 0; i < NF; i++) set_fu(i, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    next_cycle();
  endtask

  task automatic row(input int r, input logic [NF-1:0] v, input logic [23:0] p, input logic sq,
                     input logic [NF-1:0] rd, input PRN w0, input PRN w1, input int occ);
    tbl[r].valid = v;
    tbl[r].prn   = p;
    tbl[r].sq    = sq;
    tbl[r].ready = rd;
    tbl[r].w0    = w0;
    tbl[r].w1    = w1;
    tbl[r].occ   = occ;
  endtask

  // accepted results are pushed at the handshake; writes are matched by PRN
  always @(negedge clock) begin
    if (!reset || bus.squash) begin
      sb.delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        mon_prn = bus.write_data[k].prn;
        if (mon_prn != '0) begin
          hits = sb.find_first_index(e) with (e.prn == mon_prn);
          if (hits.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got write prn %0d, required none", mon_prn);
          end else begin
            check($sformatf("sb_value_prn%0d", mon_prn), 64'(bus.write_data[k].value),
                  64'(sb[hits[0]].value));
            sb.delete(hits[0]);
          end
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (bus.fu_valid[i] && bus.fu_ready[i] && bus.fu_result[i].prn != '0)
          sb.push_back(bus.fu_result[i]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle_inputs();

    row(0,  4'b0100, {6'd0, 6'd0, 6'd0, 6'd0},    1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(1,  4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(2,  4'b1111, {6'd43, 6'd42, 6'd41, 6'd40}, 1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(3,  4'b0000, 24'd0,                        1'b0, 4'b0011, 6'd40, 6'd41, 4);
    row(4,  4'b1000, {6'd44, 6'd0, 6'd0, 6'd0},    1'b0, 4'b1111, 6'd42, 6'd43, 2);
    row(5,  4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd44, 6'd0,  1);
    row(6,  4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(7,  4'b0111, {6'd0, 6'd54, 6'd51, 6'd50},  1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(8,  4'b1000, {6'd52, 6'd0, 6'd0, 6'd0},    1'b1, 4'b1000, 6'd0,  6'd0,  3);
    row(9,  4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(10, 4'b1000, {6'd53, 6'd0, 6'd0, 6'd0},    1'b0, 4'b1111, 6'd0,  6'd0,  0);
    row(11, 4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd53, 6'd0,  1);
    row(12, 4'b0000, 24'd0,                        1'b0, 4'b1111, 6'd0,  6'd0,  0);

    #3;
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("rst_ready", 64'(bus.fu_ready), 64'd0);
    check("rst_wd0", 64'(bus.write_data[0]), 64'd0);
    check("rst_wd1", 64'(bus.write_data[1]), 64'd0);

    do_reset();
    check("post_rst_ready", 64'(bus.fu_ready), 64'hF);
    check("post_rst_ptr", 64'(dut.rr_ptr), 64'd0);

    // single result from FU1
    set_fu(1, 6'd12, 32'hDEAD);
    bus.fu_valid = 4'b0010;
    @(negedge clock);
    check("single_ready", 64'(bus.fu_ready), 64'hF);
    next_cycle();
    bus.fu_valid = '0;
    @(negedge clock);
    check("single_wd0", 64'(bus.write_data[0]), 64'({32'hDEAD, 6'd12}));
    check("single_wd1_prn", 64'(bus.write_data[1].prn), 64'd0);
    check("single_cdb0", 64'(bus.cdb_prn[0]), 64'd12);
    check("single_occ", 64'(bus.occupancy), 64'd1);
    next_cycle();
    check("single_ptr", 64'(dut.rr_ptr), 64'd2);
    check("single_occ_after", 64'(bus.occupancy), 64'd0);

    // saturation: every FU refills as soon as it is ready
    do_reset();
    for (int i = 0; i < NF; i++) nxt[i] = PRN'(20 + i);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NF; i++) set_fu(i, nxt[i], val_of(nxt[i]));
      bus.fu_valid = 4'hF;
      @(negedge clock);
      exp_ready = (c == 0) ? 4'b1111 : ((c % 2 == 1) ? 4'b0011 : 4'b1100);
      check($sformatf("sat%0d_ready", c), 64'(bus.fu_ready), 64'(exp_ready));
      if (c > 0) begin
        check($sformatf("sat%0d_w0", c), 64'(bus.write_data[0].prn), 64'(20 + 2 * (c - 1)));
        check($sformatf("sat%0d_w1", c), 64'(bus.write_data[1].prn), 64'(21 + 2 * (c - 1)));
      end
      for (int i = 0; i < NF; i++) if (bus.fu_ready[i]) nxt[i] = nxt[i] + 6'd4;
      next_cycle();
    end
    idle_inputs();
    repeat (3) next_cycle();
    check("sat_drained_occ", 64'(bus.occupancy), 64'd0);

    // wrap-around from rr_ptr=3
    do_reset();
    set_fu(2, 6'd30, val_of(6'd30));
    bus.fu_valid = 4'b0100;
    next_cycle();
    set_fu(0, 6'd31, val_of(6'd31));
    set_fu(3, 6'd32, val_of(6'd32));
    bus.fu_valid = 4'b1001;
    @(negedge clock);
    check("wrap_pre_w0", 64'(bus.write_data[0].prn), 64'd30);
    next_cycle();
    bus.fu_valid = '0;
    check("wrap_ptr3", 64'(dut.rr_ptr), 64'd3);
    @(negedge clock);
    check("wrap_w0", 64'(bus.write_data[0]), 64'(wexp(6'd32)));
    check("wrap_w1", 64'(bus.write_data[1]), 64'(wexp(6'd31)));
    next_cycle();
    check("wrap_ptr1", 64'(dut.rr_ptr), 64'd1);

    // refill on grant: no bubble
    do_reset();
    set_fu(0, 6'd5, val_of(6'd5));
    bus.fu_valid = 4'b0001;
    next_cycle();
    set_fu(0, 6'd6, val_of(6'd6));
    @(negedge clock);
    check("refill_ready0", 64'(bus.fu_ready[0]), 64'd1);
    check("refill_w0_old", 64'(bus.write_data[0].prn), 64'd5);
    next_cycle();
    bus.fu_valid = '0;
    @(negedge clock);
    check("refill_w0_new", 64'(bus.write_data[0]), 64'(wexp(6'd6)));
    check("refill_occ", 64'(bus.occupancy), 64'd1);
    next_cycle();

    // table vectors: prn-0 drop, partial grants, squash with a live handshake
    do_reset();
    for (int r = 0; r < NROWS; r++) begin
      bus.fu_valid = tbl[r].valid;
      bus.squash   = tbl[r].sq;
      for (int i = 0; i < NF; i++) set_fu(i, tbl[r].prn[i], val_of(tbl[r].prn[i]));
      @(negedge clock);
      check($sformatf("tbl%0d_ready", r), 64'(bus.fu_ready), 64'(tbl[r].ready));
      check($sformatf("tbl%0d_w0", r), 64'(bus.write_data[0]), 64'(wexp(tbl[r].w0)));
      check($sformatf("tbl%0d_w1", r), 64'(bus.write_data[1]), 64'(wexp(tbl[r].w1)));
      check($sformatf("tbl%0d_cdb0", r), 64'(bus.cdb_prn[0]), 64'(tbl[r].w0));
      check($sformatf("tbl%0d_occ", r), 64'(bus.occupancy), 64'(tbl[r].occ));
      next_cycle();
    end
    idle_inputs();
    check("tbl_ptr_held", 64'(dut.rr_ptr), 64'd0);

    // asynchronous reset with all slots full
    for (int i = 0; i < NF; i++) set_fu(i, PRN'(60 + i), val_of(PRN'(60 + i)));
    bus.fu_valid = 4'hF;
    next_cycle();
    bus.fu_valid = '0;
    #2;
    check("arst_pre_occ", 64'(bus.occupancy), 64'd4);
    reset = 1'b0;
    #1;
    check("arst_occ", 64'(bus.occupancy), 64'd0);
    check("arst_ready", 64'(bus.fu_ready), 64'd0);
    check("arst_wd0", 64'(bus.write_data[0]), 64'd0);
    check("arst_wd1", 64'(bus.write_data[1]), 64'd0);
    check("arst_cdb1", 64'(bus.cdb_prn[1]), 64'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    next_cycle();
    check("arst_release_ready", 64'(bus.fu_ready), 64'hF);
    check("arst_release_ptr", 64'(dut.rr_ptr), 64'd0);
    check("arst_release_wd0", 64'(bus.write_data[0]), 64'd0);

    repeat (2) next_cycle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
